npc_pc_unit: RTL and testbench

- Consumer end of the decode-stage `npc_sel` encoding. Resolves branch and jump conditions in D using forwarded register values and computes the target.
- Owns the architectural fetch PC register, with delayed-branch (delay-slot) semantics.
- Sits between the D-stage control/forwarding muxes and instruction memory. Supplies `pc_f` to IM and the link address to the D/E pipeline register.

---
 rtl/npc_pkg.sv | 27 ++
 rtl/npc_branch_cmp.sv | 34 +++
 rtl/npc_pc_unit.sv | 104 ++++++++++
 tb/tb_npc_pc_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared next-PC select encoding and reset constants for the decode-stage control
// and the PC unit.
package npc_pkg;

  localparam logic [3:0] NPC_SEQ     = 4'd0;
  localparam logic [3:0] NPC_BEQ     = 4'd1;
  localparam logic [3:0] NPC_BNE     = 4'd2;
  localparam logic [3:0] NPC_BGEZ    = 4'd3;
  localparam logic [3:0] NPC_BLEZ    = 4'd4;
  localparam logic [3:0] NPC_BGTZ    = 4'd5;
  localparam logic [3:0] NPC_BLTZ    = 4'd6;
  localparam logic [3:0] NPC_J       = 4'd7;
  localparam logic [3:0] NPC_JR      = 4'd8;
  localparam logic [3:0] NPC_BLEZALR = 4'd9;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // True for every encoding that is a branch or jump (counted by the statistics).
  function automatic logic is_ctrl(input logic [3:0] sel);
    return (sel >= NPC_BEQ) && (sel <= NPC_BLEZALR);
  endfunction

  function automatic logic [31:0] branch_off(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/npc_branch_cmp.sv
// Decode-stage branch condition evaluator: resolves the redirect condition for a
// given npc_sel from the forwarded register operands.
module npc_branch_cmp
  import npc_pkg::*;
(
  input  logic [3:0]  npc_sel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        cond
);

  logic rs_neg;
  logic rs_zero;

  assign rs_neg  = rs_val[31];
  assign rs_zero = (rs_val == 32'd0);

  always_comb begin
    cond = 1'b0;
    case (npc_sel)
      NPC_BEQ:     cond = (rs_val == rt_val);
      NPC_BNE:     cond = (rs_val != rt_val);
      NPC_BGEZ:    cond = ~rs_neg;
      NPC_BLEZ:    cond = rs_neg | rs_zero;
      NPC_BGTZ:    cond = ~rs_neg & ~rs_zero;
      NPC_BLTZ:    cond = rs_neg;
      NPC_J:       cond = 1'b1;
      NPC_JR:      cond = 1'b1;
      NPC_BLEZALR: cond = rs_neg | rs_zero;
      default:     cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/npc_pc_unit.sv
// Fetch PC register with delay-slot redirect from D. Optional branch statistics
// counters are built only when NPC_BRSTAT_EN is defined.
module npc_pc_unit
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [3:0]  npc_sel,
  input  logic [31:0] pc_d,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  output logic [31:0] pc_f,
  output logic [31:0] link_d,
  output logic        taken_d,
  output logic        align_err,
  output logic [31:0] br_cnt,
  output logic [31:0] taken_cnt
);

  logic        cond;
  logic [31:0] target;
  logic [31:0] npc;
  logic [31:0] pc_f_q, pc_f_d;
  logic        align_err_q, align_err_d;

  npc_branch_cmp u_branch_cmp (
    .npc_sel (npc_sel),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .cond    (cond)
  );

  always_comb begin
    target = pc_d + 32'd4 + branch_off(imm16);
    case (npc_sel)
      NPC_J:       target = {pc_d[31:28], index26, 2'b00};
      NPC_JR:      target = rs_val;
      NPC_BLEZALR: target = rt_val;
      default:     ;
    endcase
  end

  // A stalled branch is dropped here and re-evaluated once the stall clears.
  assign taken_d = cond & ~stall;
  assign link_d  = pc_d + 32'd8;

  always_comb begin
    npc         = taken_d ? {target[31:2], 2'b00} : pc_f_q + 32'(PC_STEP);
    pc_f_d      = stall ? pc_f_q : npc;
    align_err_d = align_err_q | (taken_d & (target[1:0] != 2'b00));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q      <= RESET_PC;
      align_err_q <= 1'b0;
    end else begin
      pc_f_q      <= pc_f_d;
      align_err_q <= align_err_d;
    end
  end

  assign pc_f      = pc_f_q;
  assign align_err = align_err_q;

`ifdef NPC_BRSTAT_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;

  always_comb begin
    br_cnt_d    = br_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (!stall && is_ctrl(npc_sel)) begin
      br_cnt_d = br_cnt_q + 32'd1;
    end
    if (taken_d) begin
      taken_cnt_d = taken_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q    <= 32'd0;
      taken_cnt_q <= 32'd0;
    end else begin
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign br_cnt    = br_cnt_q;
  assign taken_cnt = taken_cnt_q;
`else
  assign br_cnt    = 32'd0;
  assign taken_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_npc_pc_unit.sv
// Directed, table-driven bench for npc_pc_unit; counter expectations follow
// NPC_BRSTAT_EN.
module tb_npc_pc_unit;
  import npc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [3:0]  npc_sel = 4'd0;
  logic [31:0] pc_d = 32'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic [15:0] imm16 = 16'd0;
  logic [25:0] index26 = 26'd0;
  logic [31:0] pc_f, link_d, br_cnt, taken_cnt;
  logic        taken_d, align_err;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_br = 0;
  int exp_tk = 0;

  always #5 clk = ~clk;

  npc_pc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .npc_sel   (npc_sel),
    .pc_d      (pc_d),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .imm16     (imm16),
    .index26   (index26),
    .pc_f      (pc_f),
    .link_d    (link_d),
    .taken_d   (taken_d),
    .align_err (align_err),
    .br_cnt    (br_cnt),
    .taken_cnt (taken_cnt)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic [3:0]  sel;
    logic [31:0] pcd;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] imm;
    logic [25:0] idx;
    logic        e_taken;
    logic [31:0] e_link;
    logic [31:0] e_pc;
    logic        e_al;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic s, logic [3:0] sl, logic [31:0] pd,
                              logic [31:0] a, logic [31:0] b, logic [15:0] im,
                              logic [25:0] ix, logic t, logic [31:0] lk,
                              logic [31:0] pc, logic al);
    vec_t v;
    v.rst = r; v.stl = s; v.sel = sl; v.pcd = pd; v.rs = a; v.rt = b;
    v.imm = im; v.idx = ix; v.e_taken = t; v.e_link = lk; v.e_pc = pc; v.e_al = al;
    return v;
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, want %h", name, i, got, want);
    end
  endtask

  task automatic apply(input int i, input vec_t v);
    reset   = v.rst;
    stall   = v.stl;
    npc_sel = v.sel;
    pc_d    = v.pcd;
    rs_val  = v.rs;
    rt_val  = v.rt;
    imm16   = v.imm;
    index26 = v.idx;
    #1;
    chk("taken_d", i, 32'(taken_d), 32'(v.e_taken));
    chk("link_d", i, link_d, v.e_link);
    @(posedge clk);
    #1;
    if (v.rst) begin
      exp_br = 0;
      exp_tk = 0;
    end else begin
      if (!v.stl && v.sel >= 4'd1 && v.sel <= 4'd9) exp_br++;
      if (v.e_taken) exp_tk++;
    end
    chk("pc_f", i, pc_f, v.e_pc);
    chk("align_err", i, 32'(align_err), 32'(v.e_al));
`ifdef NPC_BRSTAT_EN
    chk("br_cnt", i, br_cnt, 32'(exp_br));
    chk("taken_cnt", i, taken_cnt, 32'(exp_tk));
`else
    chk("br_cnt", i, br_cnt, 32'd0);
    chk("taken_cnt", i, taken_cnt, 32'd0);
`endif
  endtask

  initial begin
    // Reset held two cycles, then sequential fetch.
    vq.push_back(mk(1, 0, NPC_SEQ, 0, 0, 0, 0, 0, 0, 32'h8, 32'h3000, 0));
    vq.push_back(mk(1, 0, NPC_SEQ, 0, 0, 0, 0, 0, 0, 32'h8, 32'h3000, 0));
    vq.push_back(mk(0, 0, NPC_SEQ, 0, 0, 0, 0, 0, 0, 32'h8, 32'h3004, 0));
    vq.push_back(mk(0, 0, NPC_SEQ, 0, 0, 0, 0, 0, 0, 32'h8, 32'h3008, 0));
    // Conditional branches, taken and not taken.
    vq.push_back(mk(0, 0, NPC_BEQ, 32'h3004, 5, 5, 16'hFFFE, 0, 1, 32'h300C, 32'h3000, 0));
    vq.push_back(mk(0, 0, NPC_BEQ, 32'h3004, 5, 6, 16'hFFFE, 0, 0, 32'h300C, 32'h3004, 0));
    vq.push_back(mk(0, 0, NPC_BNE, 32'h3000, 5, 6, 16'h0010, 0, 1, 32'h3008, 32'h3044, 0));
    vq.push_back(mk(0, 0, NPC_BGEZ, 32'h3044, 0, 0, 16'h0004, 0, 1, 32'h304C, 32'h3058, 0));
    vq.push_back(mk(0, 0, NPC_BGEZ, 32'h3044, 32'h8000_0000, 0, 16'h0004, 0, 0, 32'h304C,
                    32'h305C, 0));
    vq.push_back(mk(0, 0, NPC_BLEZ, 32'h3058, 0, 0, 16'h0008, 0, 1, 32'h3060, 32'h307C, 0));
    vq.push_back(mk(0, 0, NPC_BGTZ, 32'h3058, 0, 0, 16'h0008, 0, 0, 32'h3060, 32'h3080, 0));
    vq.push_back(mk(0, 0, NPC_BGTZ, 32'h3080, 1, 0, 16'hFFF0, 0, 1, 32'h3088, 32'h3044, 0));
    vq.push_back(mk(0, 0, NPC_BLTZ, 32'h3044, 32'hFFFF_FFFF, 0, 16'h0010, 0, 1, 32'h304C,
                    32'h3088, 0));
    vq.push_back(mk(0, 0, NPC_BLTZ, 32'h3044, 0, 0, 16'h0010, 0, 0, 32'h304C, 32'h308C, 0));
    vq.push_back(mk(0, 0, 4'hA, 32'h3044, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 32'h304C,
                    32'h3090, 0));
    // Jumps and register-indirect targets.
    vq.push_back(mk(0, 0, NPC_J, 32'hA000_0000, 0, 0, 0, 26'h0000C40, 1, 32'hA000_0008,
                    32'hA000_3100, 0));
    vq.push_back(mk(0, 0, NPC_JR, 0, 32'h3200, 0, 0, 0, 1, 32'h8, 32'h3200, 0));
    vq.push_back(mk(0, 0, NPC_BLEZALR, 0, 32'hFFFF_FFFF, 32'h3100, 0, 0, 1, 32'h8,
                    32'h3100, 0));
    vq.push_back(mk(0, 0, NPC_BLEZALR, 0, 1, 32'h3100, 0, 0, 0, 32'h8, 32'h3104, 0));
    // Misaligned target: low bits cleared, sticky error.
    vq.push_back(mk(0, 0, NPC_JR, 0, 32'h3402, 0, 0, 0, 1, 32'h8, 32'h3400, 1));
    vq.push_back(mk(0, 0, NPC_SEQ, 0, 0, 0, 0, 0, 0, 32'h8, 32'h3404, 1));
    vq.push_back(mk(0, 0, NPC_BLEZALR, 0, 32'hFFFF_FFFF, 32'h3100, 0, 0, 1, 32'h8,
                    32'h3100, 1));
    // Stalled taken beq holds, then redirects once the stall drops.
    for (int k = 0; k < 3; k++)
      vq.push_back(mk(0, 1, NPC_BEQ, 32'h3004, 5, 5, 16'hFFFE, 0, 0, 32'h300C, 32'h3100, 1));
    vq.push_back(mk(0, 0, NPC_BEQ, 32'h3004, 5, 5, 16'hFFFE, 0, 1, 32'h300C, 32'h3000, 1));
    // Wrap-around past the top of the address space.
    vq.push_back(mk(0, 0, NPC_JR, 0, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'h8, 32'hFFFF_FFFC, 1));
    vq.push_back(mk(0, 0, NPC_SEQ, 0, 0, 0, 0, 0, 0, 32'h8, 32'h0, 1));
    // Reset beats stall; a stalled misaligned jr neither redirects nor flags.
    vq.push_back(mk(1, 1, NPC_JR, 0, 32'h3402, 0, 0, 0, 0, 32'h8, 32'h3000, 0));
    vq.push_back(mk(1, 1, NPC_JR, 0, 32'h3402, 0, 0, 0, 0, 32'h8, 32'h3000, 0));
    vq.push_back(mk(0, 1, NPC_JR, 0, 32'h3402, 0, 0, 0, 0, 32'h8, 32'h3000, 0));
    // Statistics scenario: 3 branches (2 taken) plus one stalled branch cycle.
    vq.push_back(mk(0, 0, NPC_BEQ, 32'h3004, 5, 5, 16'h0000, 0, 1, 32'h300C, 32'h3008, 0));
    vq.push_back(mk(0, 0, NPC_BNE, 32'h3004, 5, 5, 16'h0000, 0, 0, 32'h300C, 32'h300C, 0));
    vq.push_back(mk(0, 0, NPC_J, 0, 0, 0, 0, 26'h0000C40, 1, 32'h8, 32'h3100, 0));
    vq.push_back(mk(0, 1, NPC_BEQ, 32'h3004, 5, 5, 16'h0000, 0, 0, 32'h300C, 32'h3100, 0));

    for (int i = 0; i < vq.size(); i++) apply(i, vq[i]);

`ifdef NPC_BRSTAT_EN
    chk("br_cnt_final", 0, br_cnt, 32'd3);
    chk("taken_cnt_final", 0, taken_cnt, 32'd2);
`else
    chk("br_cnt_final", 0, br_cnt, 32'd0);
    chk("taken_cnt_final", 0, taken_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
